// File: rtl/baud_tick_gen_if.sv
// rtl/baud_tick_gen_if.sv - control and strobe bundle for the baud tick generator
interface baud_tick_gen_if;
  logic i_enable;
  logic i_resync;
  logic baud_tick;
  logic bit_tick;

  modport master (
    output i_enable,
    output i_resync,
    input  baud_tick,
    input  bit_tick
  );

  modport slave (
    input  i_enable,
    input  i_resync,
    output baud_tick,
    output bit_tick
  );
endinterface

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - phase-accumulator oversampling and bit-rate strobe generator
module baud_tick_gen #(
  parameter int unsigned CLK_FREQ     = 100000000,
  parameter int unsigned BAUD_RATE    = 115200,
  parameter int unsigned OVERSAMPLING = 16
) (
  input  logic           i_clk,
  input  logic           i_areset,
  baud_tick_gen_if.slave bus
);

  function automatic longint unsigned gcd64(input longint unsigned a, input longint unsigned b);
    longint unsigned x;
    longint unsigned y;
    longint unsigned t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  localparam longint unsigned TICK_HZ = 64'(BAUD_RATE) * 64'(OVERSAMPLING);
  localparam longint unsigned CLK_HZ  = 64'(CLK_FREQ);
  localparam longint unsigned G_RAW   = gcd64(TICK_HZ, CLK_HZ);
  localparam longint unsigned G       = (G_RAW == 0) ? 64'd1 : G_RAW;
  localparam longint unsigned INC_L   = TICK_HZ / G;
  localparam longint unsigned MOD_L   = CLK_HZ / G;
  localparam int              ACC_W_R = $clog2(MOD_L + INC_L);
  localparam int              ACC_W   = (ACC_W_R < 1) ? 1 : ACC_W_R;
  localparam int              OS_W    = (OVERSAMPLING > 1) ? $clog2(OVERSAMPLING) : 1;

  localparam logic [ACC_W-1:0] INC     = ACC_W'(INC_L);
  localparam logic [ACC_W-1:0] MOD     = ACC_W'(MOD_L);
  localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVERSAMPLING - 1);

  // Strobes must be at least two clocks apart, otherwise they would merge.
  if (OVERSAMPLING < 1 || BAUD_RATE < 1 || TICK_HZ * 2 > CLK_HZ) begin : g_bad_rate
    $error("baud_tick_gen: invalid rate parameters");
  end

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
  logic             baud_tick_q, baud_tick_d;
  logic             bit_tick_q, bit_tick_d;
  logic [ACC_W-1:0] sum;

  assign sum = acc_q + INC;

  always_comb begin
    acc_d       = acc_q;
    os_cnt_d    = os_cnt_q;
    baud_tick_d = 1'b0;
    bit_tick_d  = 1'b0;
    if (bus.i_resync) begin
      acc_d    = '0;
      os_cnt_d = '0;
    end else if (bus.i_enable) begin
      if (sum >= MOD) begin
        acc_d       = sum - MOD;
        baud_tick_d = 1'b1;
        bit_tick_d  = (os_cnt_q == OS_LAST);
        os_cnt_d    = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      acc_q       <= '0;
      os_cnt_q    <= '0;
      baud_tick_q <= 1'b0;
      bit_tick_q  <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      os_cnt_q    <= os_cnt_d;
      baud_tick_q <= baud_tick_d;
      bit_tick_q  <= bit_tick_d;
    end
  end

  assign bus.baud_tick = baud_tick_q;
  assign bus.bit_tick  = bit_tick_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// tb/tb_baud_tick_gen.sv - directed vector bench for baud_tick_gen (OVERSAMPLING 16 and 1)
module tb_baud_tick_gen;

  logic clk;
  logic rst;

  baud_tick_gen_if bus0 ();
  baud_tick_gen_if bus1 ();

  baud_tick_gen #(
    .CLK_FREQ(100000000),
    .BAUD_RATE(115200),
    .OVERSAMPLING(16)
  ) dut (
    .i_clk(clk),
    .i_areset(rst),
    .bus(bus0.slave)
  );

  baud_tick_gen #(
    .CLK_FREQ(100000000),
    .BAUD_RATE(115200),
    .OVERSAMPLING(1)
  ) dut1 (
    .i_clk(clk),
    .i_areset(rst),
    .bus(bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit en;
    bit rs;
    int n;
    int baud;
    int bitc;
    bit last_baud;
    bit last_bit;
    int baud1;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs[NV];

  int tests;
  int fails;
  int b2b_cnt;
  int orphan_bit;
  int os1_mis;
  bit prev_baud;

  task automatic check(input string what, input int idx, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", what, idx, act, exp);
    end
  endtask

  task automatic cycle(input bit en, input bit rs);
    bus0.i_enable = en;
    bus0.i_resync = rs;
    bus1.i_enable = en;
    bus1.i_resync = rs;
    @(posedge clk);
    #1;
    if (bus0.baud_tick && prev_baud) b2b_cnt++;
    if (bus0.bit_tick && !bus0.baud_tick) orphan_bit++;
    if (bus1.bit_tick != bus1.baud_tick) os1_mis++;
    prev_baud = bus0.baud_tick;
  endtask

  task automatic run_vec(input int i);
    int nb;
    int nbit;
    int nb1;
    nb = 0;
    nbit = 0;
    nb1 = 0;
    for (int c = 0; c < vecs[i].n; c++) begin
      cycle(vecs[i].en, vecs[i].rs);
      if (bus0.baud_tick) nb++;
      if (bus0.bit_tick) nbit++;
      if (bus1.baud_tick) nb1++;
    end
    check("baud_count", i, nb, vecs[i].baud);
    check("bit_count", i, nbit, vecs[i].bitc);
    check("last_baud", i, int'(bus0.baud_tick), int'(vecs[i].last_baud));
    check("last_bit", i, int'(bus0.bit_tick), int'(vecs[i].last_bit));
    check("os1_baud_count", i, nb1, vecs[i].baud1);
  endtask

  initial begin
    int n;
    tests = 0;
    fails = 0;
    b2b_cnt = 0;
    orphan_bit = 0;
    os1_mis = 0;
    prev_baud = 1'b0;

    //                en    rs    n      baud bit lb    lbit  os1
    vecs[0]  = '{1'b1, 1'b0, 54,    0,   0,  1'b0, 1'b0, 0};
    vecs[1]  = '{1'b1, 1'b0, 1,     1,   0,  1'b1, 1'b0, 0};
    vecs[2]  = '{1'b1, 1'b0, 1,     0,   0,  1'b0, 1'b0, 0};
    vecs[3]  = '{1'b0, 1'b0, 100,   0,   0,  1'b0, 1'b0, 0};
    vecs[4]  = '{1'b1, 1'b0, 52,    0,   0,  1'b0, 1'b0, 0};
    vecs[5]  = '{1'b1, 1'b0, 1,     1,   0,  1'b1, 1'b0, 0};
    vecs[6]  = '{1'b1, 1'b0, 759,   13,  0,  1'b0, 1'b0, 0};
    vecs[7]  = '{1'b1, 1'b0, 1,     1,   1,  1'b1, 1'b1, 1};
    vecs[8]  = '{1'b1, 1'b0, 867,   15,  0,  1'b0, 1'b0, 0};
    vecs[9]  = '{1'b1, 1'b0, 1,     1,   1,  1'b1, 1'b1, 1};
    vecs[10] = '{1'b1, 1'b0, 20,    0,   0,  1'b0, 1'b0, 0};
    vecs[11] = '{1'b1, 1'b1, 1,     0,   0,  1'b0, 1'b0, 0};
    vecs[12] = '{1'b1, 1'b0, 54,    0,   0,  1'b0, 1'b0, 0};
    vecs[13] = '{1'b1, 1'b0, 1,     1,   0,  1'b1, 1'b0, 0};
    vecs[14] = '{1'b1, 1'b0, 813,   14,  0,  1'b0, 1'b0, 0};
    vecs[15] = '{1'b1, 1'b0, 1,     1,   1,  1'b1, 1'b1, 1};
    vecs[16] = '{1'b1, 1'b0, 54,    0,   0,  1'b0, 1'b0, 0};
    vecs[17] = '{1'b1, 1'b0, 1,     1,   0,  1'b1, 1'b0, 0};
    vecs[18] = '{1'b1, 1'b0, 15570, 287, 18, 1'b1, 1'b1, 18};
    vecs[19] = '{1'b1, 1'b0, 54,    0,   0,  1'b0, 1'b0, 0};
    vecs[20] = '{1'b1, 1'b0, 1,     1,   0,  1'b1, 1'b0, 0};
    vecs[21] = '{1'b0, 1'b1, 1,     0,   0,  1'b0, 1'b0, 0};
    vecs[22] = '{1'b1, 1'b0, 54,    0,   0,  1'b0, 1'b0, 0};
    vecs[23] = '{1'b1, 1'b0, 1,     1,   0,  1'b1, 1'b0, 0};

    rst = 1'b1;
    bus0.i_enable = 1'b0;
    bus0.i_resync = 1'b0;
    bus1.i_enable = 1'b0;
    bus1.i_resync = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_baud", 0, int'(bus0.baud_tick), 0);
    check("reset_bit", 0, int'(bus0.bit_tick), 0);
    check("reset_os1_baud", 0, int'(bus1.baud_tick), 0);
    bus0.i_enable = 1'b1;
    bus1.i_enable = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i <= 15; i++) run_vec(i);

    // Both DUTs are showing a strobe here; reset must clear it with no clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_baud", 0, int'(bus0.baud_tick), 0);
    check("async_rst_bit", 0, int'(bus0.bit_tick), 0);
    check("async_rst_os1_baud", 0, int'(bus1.baud_tick), 0);
    prev_baud = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 16; i < NV; i++) run_vec(i);

    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        cycle(1'b1, 1'b0);
        n++;
      end while (!bus0.baud_tick && n < 100);
      tests++;
      if (n != 54 && n != 55) begin
        fails++;
        $display("FAIL tick_gap[%0d]: got %0d clocks, expected 54 or 55", k, n);
      end
    end

    check("back_to_back_strobes", 0, b2b_cnt, 0);
    check("bit_without_baud", 0, orphan_bit, 0);
    check("os1_bit_ne_baud", 0, os1_mis, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
